// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM micro-op fetch controller: default widths,
// micro-op field positions, FSM state encoding and buffer address shifts.
package gemm_pkg;

   localparam int UOP_WIDTH_DEF     = 32;
   localparam int UPC_WIDTH_DEF     = 13;
   localparam int BUF_ADR_WIDTH_DEF = 32;
   localparam int ACC_IDX_WIDTH_DEF = 12;
   localparam int INP_IDX_WIDTH_DEF = 12;
   localparam int WGT_IDX_WIDTH_DEF = 11;
   localparam int ITR_WIDTH_DEF     = 14;

   localparam int ACC_LSB = 0;
   localparam int ACC_MSB = 10;
   localparam int INP_LSB = 11;
   localparam int INP_MSB = 21;
   localparam int WGT_LSB = 22;
   localparam int WGT_MSB = 31;

   // inp rows are 16 bytes, wgt rows are 128 bytes
   localparam int INP_ADDR_SHIFT = 4;
   localparam int WGT_ADDR_SHIFT = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/gemm_fetch_ctrl_if.sv
// Memory-side bundle of the fetch controller.
//   master (controller): drives mem_en, upc, inp/wgt read addresses, acc_idx,
//                        mac_valid; receives stall and the uop BRAM data.
//   slave  (datapath):   the mirror image.
interface gemm_fetch_ctrl_if
   import gemm_pkg::*;
#(
   parameter int UOP_WIDTH     = UOP_WIDTH_DEF,
   parameter int UPC_WIDTH     = UPC_WIDTH_DEF,
   parameter int BUF_ADR_WIDTH = BUF_ADR_WIDTH_DEF,
   parameter int ACC_IDX_WIDTH = ACC_IDX_WIDTH_DEF
);
   logic                     stall;
   logic                     mem_en;
   logic [UPC_WIDTH-1:0]     upc;
   logic [UOP_WIDTH-1:0]     uop;
   logic [BUF_ADR_WIDTH-1:0] inp_mem_rd_addr;
   logic [BUF_ADR_WIDTH-1:0] wgt_mem_rd_addr;
   logic [ACC_IDX_WIDTH-1:0] acc_idx;
   logic                     mac_valid;

   modport master (
      input  stall, uop,
      output mem_en, upc, inp_mem_rd_addr, wgt_mem_rd_addr, acc_idx, mac_valid
   );

   modport slave (
      output stall, uop,
      input  mem_en, upc, inp_mem_rd_addr, wgt_mem_rd_addr, acc_idx, mac_valid
   );
endinterface

// File: rtl/gemm_loop_cnt.sv
// Three-level nested loop counter: i0 (outer) x i1 (inner) x upc (innermost).
//   load_i      : latch range/counts and restart at (0, 0, bgn)
//   step_i      : advance one beat unless hold_i is high
//   upc_o       : current micro-op address
//   upc_wrap_o  : current beat is the last upc of the range
//   in_wrap_o   : ... and also the last inner iteration
//   last_o      : current beat is the final beat of the launch
module gemm_loop_cnt
   import gemm_pkg::*;
#(
   parameter int UPC_WIDTH = UPC_WIDTH_DEF,
   parameter int ITR_WIDTH = ITR_WIDTH_DEF
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [UPC_WIDTH-1:0] bgn_i,
   input  logic [UPC_WIDTH-1:0] end_i,
   input  logic [ITR_WIDTH-1:0] iter_out_i,
   input  logic [ITR_WIDTH-1:0] iter_in_i,
   input  logic                 step_i,
   input  logic                 hold_i,
   output logic [UPC_WIDTH-1:0] upc_o,
   output logic                 upc_wrap_o,
   output logic                 in_wrap_o,
   output logic                 last_o
);
   logic [UPC_WIDTH-1:0] upc_q, bgn_q, end_q;
   logic [ITR_WIDTH-1:0] i0_q, i1_q, iter_out_q, iter_in_q;
   logic                 advance;

   assign advance    = step_i && !hold_i;
   assign upc_o      = upc_q;
   assign upc_wrap_o = (upc_q == end_q - UPC_WIDTH'(1));
   assign in_wrap_o  = upc_wrap_o && (i1_q == iter_in_q - ITR_WIDTH'(1));
   assign last_o     = in_wrap_o && (i0_q == iter_out_q - ITR_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upc_q      <= '0;
         bgn_q      <= '0;
         end_q      <= '0;
         i0_q       <= '0;
         i1_q       <= '0;
         iter_out_q <= '0;
         iter_in_q  <= '0;
      end else if (load_i) begin
         upc_q      <= bgn_i;
         bgn_q      <= bgn_i;
         end_q      <= end_i;
         iter_out_q <= iter_out_i;
         iter_in_q  <= iter_in_i;
         i0_q       <= '0;
         i1_q       <= '0;
      end else if (advance) begin
         if (upc_wrap_o) begin
            upc_q <= bgn_q;
            if (in_wrap_o) begin
               i1_q <= '0;
               i0_q <= i0_q + ITR_WIDTH'(1);
            end else begin
               i1_q <= i1_q + ITR_WIDTH'(1);
            end
         end else begin
            upc_q <= upc_q + UPC_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/gemm_fetch_ctrl.sv
// GEMM micro-op fetch controller. Walks uop range x inner x outer loops,
// decodes each uop, adds running per-buffer offsets and issues inp/wgt BRAM
// read addresses plus the accumulator index, one beat per non-stalled cycle.
//   clk, rst_n          : clock, async active-low reset
//   start/busy/done     : launch request, in-flight flag, completion pulse
//   uop_bgn/uop_end     : uop range [bgn, end); iter_out/iter_in loop counts
//   *_f_out / *_f_in    : per-loop index strides for acc/inp/wgt
//   mem (master)        : stall in, uop in; mem_en, upc, addresses,
//                         acc_idx, mac_valid out
//
// state    | meaning
// ST_IDLE  | waiting for start (ignored during the done cycle)
// ST_RUN   | issuing one uop per non-stalled cycle
// ST_DRAIN | last uop issued; waiting for the valid pipe to empty
module gemm_fetch_ctrl
   import gemm_pkg::*;
#(
   parameter int UOP_WIDTH     = UOP_WIDTH_DEF,
   parameter int UPC_WIDTH     = UPC_WIDTH_DEF,
   parameter int BUF_ADR_WIDTH = BUF_ADR_WIDTH_DEF,
   parameter int ACC_IDX_WIDTH = ACC_IDX_WIDTH_DEF,
   parameter int INP_IDX_WIDTH = INP_IDX_WIDTH_DEF,
   parameter int WGT_IDX_WIDTH = WGT_IDX_WIDTH_DEF,
   parameter int ITR_WIDTH     = ITR_WIDTH_DEF
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic [UPC_WIDTH-1:0]     uop_bgn,
   input  logic [UPC_WIDTH-1:0]     uop_end,
   input  logic [ITR_WIDTH-1:0]     iter_out,
   input  logic [ITR_WIDTH-1:0]     iter_in,
   input  logic [ACC_IDX_WIDTH-1:0] acc_f_out,
   input  logic [ACC_IDX_WIDTH-1:0] acc_f_in,
   input  logic [INP_IDX_WIDTH-1:0] inp_f_out,
   input  logic [INP_IDX_WIDTH-1:0] inp_f_in,
   input  logic [WGT_IDX_WIDTH-1:0] wgt_f_out,
   input  logic [WGT_IDX_WIDTH-1:0] wgt_f_in,
   gemm_fetch_ctrl_if.master        mem
);
   fetch_state_e state_q, state_d;
   logic         done_q, done_d, degen_q;
   logic         start_ok, advance, run_ok, issue;
   logic         upc_wrap, in_wrap, last_beat;

   logic [ACC_IDX_WIDTH-1:0] acc_fo_q, acc_fi_q, acc_out_q, acc_in_q, acc_off_q, acc2_q, acc_idx_q;
   logic [INP_IDX_WIDTH-1:0] inp_fo_q, inp_fi_q, inp_out_q, inp_in_q, inp_off_q, inp_idx;
   logic [WGT_IDX_WIDTH-1:0] wgt_fo_q, wgt_fi_q, wgt_out_q, wgt_in_q, wgt_off_q, wgt_idx;
   logic [BUF_ADR_WIDTH-1:0] inp_addr_q, wgt_addr_q;
   logic                     v1_q, v2_q, mac_valid_q;

   assign start_ok = (state_q == ST_IDLE) && !done_q && start;
   assign advance  = !mem.stall;
   assign run_ok   = (state_q == ST_RUN) && !degen_q;
   assign issue    = run_ok && advance;

   gemm_loop_cnt #(.UPC_WIDTH(UPC_WIDTH), .ITR_WIDTH(ITR_WIDTH)) u_loop_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (start_ok),
      .bgn_i      (uop_bgn),
      .end_i      (uop_end),
      .iter_out_i (iter_out),
      .iter_in_i  (iter_in),
      .step_i     (run_ok),
      .hold_i     (mem.stall),
      .upc_o      (mem.upc),
      .upc_wrap_o (upc_wrap),
      .in_wrap_o  (in_wrap),
      .last_o     (last_beat)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_RUN;
         ST_RUN:   if (advance && (degen_q || last_beat)) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (advance && !v1_q && !v2_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // done is registered, so busy must cover the done cycle explicitly
   assign busy   = (state_q != ST_IDLE) || done_q;
   assign done   = done_q;
   assign mem.mem_en = busy && !mem.stall;

   // running offsets: *_out = i0*f_out, *_in = i1*f_in for the current beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         degen_q  <= 1'b0;
         acc_fo_q <= '0; acc_fi_q <= '0; acc_out_q <= '0; acc_in_q <= '0;
         inp_fo_q <= '0; inp_fi_q <= '0; inp_out_q <= '0; inp_in_q <= '0;
         wgt_fo_q <= '0; wgt_fi_q <= '0; wgt_out_q <= '0; wgt_in_q <= '0;
      end else if (start_ok) begin
         degen_q  <= (iter_out == '0) || (iter_in == '0) || (uop_bgn >= uop_end);
         acc_fo_q <= acc_f_out; acc_fi_q <= acc_f_in; acc_out_q <= '0; acc_in_q <= '0;
         inp_fo_q <= inp_f_out; inp_fi_q <= inp_f_in; inp_out_q <= '0; inp_in_q <= '0;
         wgt_fo_q <= wgt_f_out; wgt_fi_q <= wgt_f_in; wgt_out_q <= '0; wgt_in_q <= '0;
      end else if (issue) begin
         if (in_wrap) begin
            acc_in_q  <= '0;
            inp_in_q  <= '0;
            wgt_in_q  <= '0;
            acc_out_q <= acc_out_q + acc_fo_q;
            inp_out_q <= inp_out_q + inp_fo_q;
            wgt_out_q <= wgt_out_q + wgt_fo_q;
         end else if (upc_wrap) begin
            acc_in_q <= acc_in_q + acc_fi_q;
            inp_in_q <= inp_in_q + inp_fi_q;
            wgt_in_q <= wgt_in_q + wgt_fi_q;
         end
      end
   end

   assign inp_idx = INP_IDX_WIDTH'(mem.uop[INP_MSB:INP_LSB]) + inp_off_q;
   assign wgt_idx = WGT_IDX_WIDTH'(mem.uop[WGT_MSB:WGT_LSB]) + wgt_off_q;

   // stage 1 lines up with the uop BRAM read, stage 2 with the address
   // register, stage 3 with the inp/wgt BRAM read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         acc_off_q   <= '0;
         inp_off_q   <= '0;
         wgt_off_q   <= '0;
         v2_q        <= 1'b0;
         acc2_q      <= '0;
         inp_addr_q  <= '0;
         wgt_addr_q  <= '0;
         mac_valid_q <= 1'b0;
         acc_idx_q   <= '0;
      end else if (advance) begin
         v1_q        <= issue;
         acc_off_q   <= acc_out_q + acc_in_q;
         inp_off_q   <= inp_out_q + inp_in_q;
         wgt_off_q   <= wgt_out_q + wgt_in_q;
         v2_q        <= v1_q;
         acc2_q      <= ACC_IDX_WIDTH'(mem.uop[ACC_MSB:ACC_LSB]) + acc_off_q;
         inp_addr_q  <= BUF_ADR_WIDTH'(inp_idx) << INP_ADDR_SHIFT;
         wgt_addr_q  <= BUF_ADR_WIDTH'(wgt_idx) << WGT_ADDR_SHIFT;
         mac_valid_q <= v2_q;
         acc_idx_q   <= acc2_q;
      end
   end

   assign mem.inp_mem_rd_addr = inp_addr_q;
   assign mem.wgt_mem_rd_addr = wgt_addr_q;
   assign mem.acc_idx         = acc_idx_q;
   assign mem.mac_valid       = mac_valid_q;

endmodule

// File: tb/tb_gemm_fetch_ctrl.sv
module tb_gemm_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [12:0] c_bgn, c_end;
   logic [13:0] c_io, c_ii;
   logic [11:0] c_acc_fo, c_acc_fi, c_inp_fo, c_inp_fi;
   logic [10:0] c_wgt_fo, c_wgt_fi;

   gemm_fetch_ctrl_if #(.UOP_WIDTH(32), .UPC_WIDTH(13), .BUF_ADR_WIDTH(32), .ACC_IDX_WIDTH(12)) mif ();

   gemm_fetch_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .uop_bgn   (c_bgn),
      .uop_end   (c_end),
      .iter_out  (c_io),
      .iter_in   (c_ii),
      .acc_f_out (c_acc_fo),
      .acc_f_in  (c_acc_fi),
      .inp_f_out (c_inp_fo),
      .inp_f_in  (c_inp_fi),
      .wgt_f_out (c_wgt_fo),
      .wgt_f_in  (c_wgt_fi),
      .mem       (mif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // uop BRAM, one-cycle read latency
   logic [31:0] uop_mem [0:8191];
   always @(posedge clk) if (mif.mem_en) mif.uop <= uop_mem[mif.upc];

   typedef struct {
      logic [31:0] acc;
      logic [31:0] inp;
      logic [31:0] wgt;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   // consumer side: a beat is taken when mac_valid is high and stall is low;
   // addresses lead mac_valid by one advancing cycle
   int          beats = 0;
   int          first_mac = -1;
   logic [31:0] sh_inp = '0, sh_wgt = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (mif.mac_valid && !mif.stall) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("acc_idx", 32'(mif.acc_idx), e.acc);
               chk("inp_addr", sh_inp, e.inp);
               chk("wgt_addr", sh_wgt, e.wgt);
            end
            beats++;
            if (first_mac < 0) first_mac = cyc;
         end
         if (!mif.stall) begin
            sh_inp = mif.inp_mem_rd_addr;
            sh_wgt = mif.wgt_mem_rd_addr;
         end
      end
   end

   function automatic logic [31:0] mk_uop(input int wgt, input int inp, input int acc);
      logic [31:0] w;
      w = {10'(wgt), 11'(inp), 11'(acc)};
      return w;
   endfunction

   task automatic set_cfg(input int bgn, input int en, input int io, input int ii,
                          input int afo, input int afi, input int ifo, input int ifi,
                          input int wfo, input int wfi);
      c_bgn = 13'(bgn); c_end = 13'(en); c_io = 14'(io); c_ii = 14'(ii);
      c_acc_fo = 12'(afo); c_acc_fi = 12'(afi);
      c_inp_fo = 12'(ifo); c_inp_fi = 12'(ifi);
      c_wgt_fo = 11'(wfo); c_wgt_fi = 11'(wfi);
   endtask

   // reference model: direct multiply, loop order i0 > i1 > upc
   task automatic build_expect(output int n);
      exp_t        e;
      logic [31:0] w;
      int          t;
      n = 0;
      for (int a = 0; a < int'(c_io); a++)
         for (int b = 0; b < int'(c_ii); b++)
            for (int u = int'(c_bgn); u < int'(c_end); u++) begin
               w = uop_mem[u];
               t = int'(w[10:0]) + a * int'(c_acc_fo) + b * int'(c_acc_fi);
               e.acc = 32'(t) & 32'hFFF;
               t = int'(w[21:11]) + a * int'(c_inp_fo) + b * int'(c_inp_fi);
               e.inp = (32'(t) & 32'hFFF) << 4;
               t = int'(w[31:22]) + a * int'(c_wgt_fo) + b * int'(c_wgt_fi);
               e.wgt = (32'(t) & 32'h7FF) << 7;
               sb.push_back(e);
               n++;
            end
   endtask

   // poke: re-assert start and disturb strides mid-run; both must be ignored
   task automatic launch(input string tag, input int stall_at, input int stall_len, input bit poke);
      int n, e0, dcyc, rel, exp_done;
      build_expect(n);
      beats = 0;
      first_mac = -1;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      start = 1'b0;
      dcyc = -1;
      for (int k = 0; k < 400 && dcyc < 0; k++) begin
         rel = cyc - e0;
         mif.stall = (stall_len > 0) && (rel >= stall_at) && (rel < stall_at + stall_len);
         start = poke && (rel == 2);
         if (poke && rel == 2) begin
            c_acc_fi = c_acc_fi + 12'd1;
            c_inp_fo = c_inp_fo + 12'd3;
         end
         @(negedge clk);
         if (rel == 0) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_mem_en_run"}, 32'(mif.mem_en), 32'd1);
         end
         if (mif.stall) chk({tag, "_mem_en_stall"}, 32'(mif.mem_en), 32'd0);
         if (done) begin
            dcyc = cyc;
            chk({tag, "_busy_done"}, 32'(busy), 32'd1);
         end
         @(posedge clk); #1;
      end
      mif.stall = 1'b0;
      start = 1'b0;
      exp_done = (n == 0) ? 2 : n + 3 + stall_len;
      chk({tag, "_no_timeout"}, 32'(dcyc >= 0), 32'd1);
      chk({tag, "_done_lat"}, 32'(dcyc - e0), 32'(exp_done));
      chk({tag, "_beats"}, 32'(beats), 32'(n));
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      if (n > 0) chk({tag, "_first_mac"}, 32'(first_mac - e0), 32'd3);
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_mac_valid"}, 32'(mif.mac_valid), 32'd0);
      chk({tag, "_mem_en"}, 32'(mif.mem_en), 32'd0);
      chk({tag, "_upc"}, 32'(mif.upc), 32'd0);
      chk({tag, "_acc_idx"}, 32'(mif.acc_idx), 32'd0);
      chk({tag, "_inp_addr"}, mif.inp_mem_rd_addr, 32'd0);
      chk({tag, "_wgt_addr"}, mif.wgt_mem_rd_addr, 32'd0);
   endtask

   task automatic abort_run();
      int n;
      set_cfg(0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
      build_expect(n);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      sb.delete();
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mif.stall = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8192; i++) uop_mem[i] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // four uops, identity fields, strides zero
      for (int i = 0; i < 4; i++) uop_mem[i] = mk_uop(i, i, i);
      set_cfg(0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
      launch("basic", 0, 0, 1'b0);

      // single uop, 2x3 loops, acc strides 10/1
      uop_mem[2] = mk_uop(9, 3, 5);
      set_cfg(2, 3, 2, 3, 10, 1, 7, 2, 4, 1);
      launch("loops", 0, 0, 1'b0);

      // degenerate launches
      set_cfg(0, 4, 2, 0, 1, 1, 1, 1, 1, 1);
      launch("degen_ii", 0, 0, 1'b0);
      set_cfg(5, 5, 2, 2, 1, 1, 1, 1, 1, 1);
      launch("degen_rng", 0, 0, 1'b0);

      // three-cycle stall in the middle of a four-uop run
      uop_mem[2] = mk_uop(2, 2, 2);
      set_cfg(0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
      launch("stall", 4, 3, 1'b0);

      // reset mid-run, then start on the first edge after release
      abort_run();
      set_cfg(0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
      launch("post_rst", 0, 0, 1'b0);

      // index wrap on the inp buffer (and acc/wgt pushed to their tops)
      uop_mem[10] = mk_uop(11'h3FF, 11'h7FF, 11'h7FF);
      set_cfg(10, 11, 1, 2, 0, 1, 0, 12'h801, 0, 1);
      launch("wrap", 0, 0, 1'b0);

      // mixed run with random uops/strides, start re-asserted while busy
      for (int i = 4; i < 9; i++) uop_mem[i] = $urandom;
      set_cfg(4, 9, 3, 2, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      launch("mixed", 6, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gemm_fetch_ctrl.md
GEMM_FETCH_CTRL -- requirements
Module: gemm_fetch_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): UOP_WIDTH 32 micro-op word; UPC_WIDTH 13 uop address; BUF_ADR_WIDTH 32 buffer byte address; ACC_IDX_WIDTH 12, INP_IDX_WIDTH 12, WGT_IDX_WIDTH 11 row-index widths; ITR_WIDTH 14 loop count.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 start in 1: launch request; busy out 1: sequence in flight; done out 1: one-cycle completion pulse.
REQ-004 uop_bgn, uop_end in UPC_WIDTH: uop range [bgn, end); iter_out, iter_in in ITR_WIDTH: loop counts.
REQ-005 acc_f_out, acc_f_in in ACC_IDX_WIDTH; inp_f_out, inp_f_in in INP_IDX_WIDTH; wgt_f_out, wgt_f_in in WGT_IDX_WIDTH: per-loop index strides.
REQ-006 stall in 1: downstream hold; mem_en out 1: enable to uop/inp/wgt BRAMs.
REQ-007 upc out UPC_WIDTH; uop in UOP_WIDTH (1-cycle BRAM latency).
REQ-008 inp_mem_rd_addr, wgt_mem_rd_addr out BUF_ADR_WIDTH; acc_idx out ACC_IDX_WIDTH; mac_valid out 1: inp/wgt BRAM data and acc_idx valid this cycle.

Function
REQ-009 SHALL decode uop as acc = uop[10:0], inp = uop[21:11], wgt = uop[31:22], each zero-extended to its index width.
REQ-010 SHALL iterate i0 in [0,iter_out), i1 in [0,iter_in), upc in [uop_bgn,uop_end), upc innermost; one uop issued per non-stalled cycle.
REQ-011 SHALL compute idx = field + i0*f_out + i1*f_in per buffer, modulo 2^index width, via running offset adders (no multipliers).
REQ-012 SHALL drive inp_mem_rd_addr = inp_idx<<4 and wgt_mem_rd_addr = wgt_idx<<7, upper bits zero.
REQ-013 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN after last uop issued; DRAIN->IDLE when pipeline empty, asserting done that cycle.
REQ-014 start SHALL be sampled only in IDLE; start while busy is ignored; parameters are latched at start.
REQ-015 busy SHALL be high from the cycle after start acceptance through the done cycle.
REQ-016 Latency: start sampled at edge E0 -> upc=uop_bgn after E0; addresses registered at E2; first mac_valid and acc_idx after E3.
REQ-017 mac_valid SHALL pulse exactly iter_out*iter_in*(uop_end-uop_bgn) times per launch, in loop order.
REQ-018 done SHALL assert the cycle after the final mac_valid.
REQ-019 Degenerate launch (iter_out=0, iter_in=0, or uop_bgn>=uop_end): no mac_valid, RUN->DRAIN immediately, done 2 cycles after E0.
REQ-020 stall high: mem_en=0, all pipeline registers, counters and outputs hold; mac_valid holds its value but SHALL NOT count as a new beat; resume loses no beat.
REQ-021 mem_en SHALL be ~stall while busy and 0 in IDLE.
REQ-022 Offsets SHALL wrap silently on overflow.

Reset
REQ-023 rst_n low SHALL immediately force IDLE and zero all outputs and counters, including mid-sequence; no done pulse is generated for an aborted run.
REQ-024 First start SHALL be honoured on the first edge after rst_n deasserts.

Structure
REQ-025 Shared package gemm_pkg: width parameters, uop field positions, FSM state encoding, address shift constants (4, 7).
REQ-026 One sub-module gemm_loop_cnt: three-level nested counter with last-beat flag and hold input; the rest (decode, offset adders, FSM, valid pipe) stays in gemm_fetch_ctrl.

Verification
REQ-027 bgn=0,end=4,iter 1x1, strides 0, uop n = {wgt=n,inp=n,acc=n} -> 4 mac_valid from E3, inp addr 0,16,32,48, wgt addr 0,128,256,384, done after E7.
REQ-028 bgn=2,end=3, iter_out=2,iter_in=3, acc_f_out=10,acc_f_in=1, uop acc=5 -> acc_idx 5,6,7,15,16,17, 6 valids, done next cycle.
REQ-029 iter_in=0 -> zero mac_valid, done after E2, busy low after done.
REQ-030 stall high 3 cycles mid-run (4-uop run) -> mem_en low, outputs frozen, total mac_valid count still 4, done 3 cycles later than unstalled.
REQ-031 rst_n low mid-run then start -> outputs 0 immediately, no done, new run completes with correct count.
REQ-032 inp field 0x7FF, inp_f_in=0x801, iter_in=2 -> second inp idx 0x000 (wrap), addr 0x0.
